mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported instruction/data memory between the fetch stage (IF)
//   and the load/store stage (D). Picks one requester and drives the address/wdata
//   mux select and the read-data demux select. Runs the memory request/ack handshake
//   with a watchdog timeout. Returns stall and ack signals to the pipeline.
// PARAMETERS
//   AW       32  address width
//   DW       32  data width
//   TIMEOUT  16  cycles of mem_req without mem_ack before abort (legal range 1..255)
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   if_req     in   1   fetch request; level, held until if_ack
//   if_addr    in   AW  fetch address, stable while if_req
//   if_ack     out  1   one-cycle completion pulse to fetch
//   if_rdata   out  DW  instruction word, valid with if_ack
//   if_stall   out  1   if_req & ~if_ack
//   d_req      in   1   data request; level, held until d_ack
//   d_we       in   1   1=write, 0=read
//   d_addr     in   AW  data address
//   d_wdata    in   DW  write data
//   d_ack      out  1   one-cycle completion pulse to data stage
//   d_rdata    out  DW  load data, valid with d_ack (0 for writes)
//   d_stall    out  1   d_req & ~d_ack
//   err        out  1   with any ack: 1 = transaction aborted by timeout
//   gnt_sel    out  1   mux/demux select: 0=fetch, 1=data; held for whole transaction
//   mem_req    out  1   memory request, held until mem_ack or timeout
//   mem_we     out  1   memory write enable
//   mem_addr   out  AW  registered granted address
//   mem_wdata  out  DW  registered granted write data
//   mem_rdata  in   DW  memory read data, valid with mem_ack
//   mem_ack    in   1   memory completion, one cycle
// BEHAVIOUR
//   - FSM states: IDLE, BUSY, RESP.
//     IDLE: if any req, latch winner addr/we/wdata and set gnt_sel -> BUSY.
//     BUSY: mem_req=1. On mem_ack: capture mem_rdata -> RESP.
//       Timeout counter reaches TIMEOUT without mem_ack: err=1, rdata=0 -> RESP.
//     RESP: ack pulse to granted requester for exactly one cycle -> IDLE.
//   - Latency: req sampled in cycle N (IDLE), mem_req from N+1.
//     mem_ack in cycle M gives ack in M+1; minimum is ack at N+2.
//     Next grant is sampled at M+2.
//   - Requester must drop or renew req in the cycle after its ack. Any req seen in
//     IDLE is treated as a new transaction.
//   - Default arbitration: fixed priority, data over fetch.
//   - Timeout counter: 8-bit, cleared on entry to BUSY, increments each BUSY cycle.
//     Abort fires on the cycle the count equals TIMEOUT-1 and mem_ack is absent.
//     If mem_ack arrives in that same cycle, mem_ack wins and err=0.
//   - mem_ack outside BUSY is ignored. mem_rdata is ignored for writes.
//   - mem_addr, mem_wdata, mem_we and gnt_sel are registered.
//     They are stable for the whole transaction, from BUSY entry through RESP.
//   - Reset (any state): next cycle IDLE, all outputs 0 (mem_req, acks, err,
//     gnt_sel, rdata, mem_addr/wdata/we). An in-flight transaction is dropped with
//     no ack; the requester retries.
// CONFIGURATION
//   ARB_RR_EN defined: round-robin arbitration. A last-grant bit flips each time
//     both requesters contend in IDLE; the other requester wins the tie. Reset value
//     of the bit = data, so the first tie goes to fetch. Single requester is always
//     granted.
//   ARB_RR_EN undefined: fixed data-over-fetch priority; no last-grant state.
// TESTING
//   1. if_req@0 addr 0x100, mem_ack@3 rdata 0xDEADBEEF
//      -> mem_req 1..3, mem_addr 0x100, gnt_sel 0; if_ack@4, if_rdata 0xDEADBEEF, err 0.
//   2. if_req and d_req both @0, d_addr 0x2000, mem_ack 1 cycle after each mem_req
//      -> data served first (gnt_sel 1, d_ack@3), then fetch (if_ack@6).
//      if_stall high 0..5.
//   3. d_req d_we=1 addr 0x2004 wdata 0x12345678
//      -> mem_we 1, mem_wdata 0x12345678; d_ack with d_rdata 0, err 0.
//   4. TIMEOUT=16, d_req, mem_ack never asserted
//      -> mem_req high exactly 16 cycles; d_ack with err 1, d_rdata 0; a later
//      stray mem_ack is ignored.
//   5. rst asserted in the 2nd BUSY cycle of a fetch
//      -> next cycle IDLE, mem_req 0, no if_ack; held if_req re-granted after rst
//      drops.
//   6. ARB_RR_EN, both reqs held continuously
//      -> grant order F,D,F,D; with macro undefined, D every time.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the fetch-stage, data-stage and memory-side handshake signals of
//   the shared single-ported memory arbiter.
//
//   Modports
//     slave  : the arbiter (consumes requests and memory completion,
//              produces acks, stalls, grant select and the memory request)
//     master : the environment around it (pipeline stages plus the memory)
//
//   Signal summary
//     if_req/if_addr                       fetch request (in to arbiter)
//     if_ack/if_rdata/if_stall             fetch completion (out of arbiter)
//     d_req/d_we/d_addr/d_wdata            data request (in to arbiter)
//     d_ack/d_rdata/d_stall                data completion (out of arbiter)
//     err                                  timeout flag, valid with any ack
//     gnt_sel                              0 = fetch owns the port, 1 = data
//     mem_req/mem_we/mem_addr/mem_wdata    memory request (out of arbiter)
//     mem_rdata/mem_ack                    memory completion (in to arbiter)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_stall;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_stall;

  logic          err;
  logic          gnt_sel;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ack,
    output if_ack, if_rdata, if_stall,
    output d_ack, d_rdata, d_stall,
    output err, gnt_sel,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ack,
    input  if_ack, if_rdata, if_stall,
    input  d_ack, d_rdata, d_stall,
    input  err, gnt_sel,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported instruction/data memory between the fetch stage
//   and the load/store stage. A three-state FSM (IDLE -> BUSY -> RESP) grants
//   one requester, holds a registered address/wdata/we and mux select for the
//   whole transaction, runs the mem_req/mem_ack handshake under an 8-bit
//   watchdog, and returns a one-cycle ack (with err on timeout) to the winner.
//
//   Ports
//     clk    rising-edge clock
//     rst    synchronous reset, active-high (drops any in-flight transaction)
//     port   mem_port_arbiter_if.slave, see the interface for signal list
//
//   Parameters
//     AW, DW   address / data width
//     TIMEOUT  BUSY cycles without mem_ack before abort (1..255)
//
//   Configuration macro
//     ARB_RR_EN  defined  : round-robin between the two requesters on a tie,
//                           using a last-grant bit that resets to "data"
//                undefined: fixed priority, data over fetch
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave port
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Count value on which the watchdog gives up: the first BUSY cycle sees 0,
  // so mem_req is high for exactly TIMEOUT cycles before the abort.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e        state_q,     state_d;
  logic [7:0]    cnt_q,       cnt_d;
  logic          gnt_sel_q,   gnt_sel_d;
  logic          mem_req_q,   mem_req_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q,    if_ack_d;
  logic          d_ack_q,     d_ack_d;
  logic          err_q,       err_d;
  logic [DW-1:0] if_rdata_q,  if_rdata_d;
  logic [DW-1:0] d_rdata_q,   d_rdata_d;
`ifdef ARB_RR_EN
  // 1 = data won the last tie, 0 = fetch won it.
  logic          last_q,      last_d;
`endif

  logic          any_req_s;
  logic          pick_d_s;
  logic [DW-1:0] rsp_data_s;

  assign any_req_s = port.if_req | port.d_req;

  // Arbitration: choose which requester wins when the FSM is in IDLE.
  always_comb begin
    pick_d_s = 1'b0;
`ifdef ARB_RR_EN
    if (port.if_req && port.d_req) begin
      pick_d_s = ~last_q;
    end else begin
      pick_d_s = port.d_req;
    end
`else
    pick_d_s = port.d_req;
`endif
  end

  // Read data returned to the winner: writes always return zero.
  always_comb begin
    rsp_data_s = '0;
    if (mem_we_q) begin
      rsp_data_s = '0;
    end else begin
      rsp_data_s = port.mem_rdata;
    end
  end

  // Next-state and registered-output logic of the transaction FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_sel_d   = gnt_sel_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_req_d   = 1'b0;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = '0;
    d_rdata_d   = '0;
`ifdef ARB_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d   = ST_BUSY;
          cnt_d     = 8'd0;
          mem_req_d = 1'b1;
          gnt_sel_d = pick_d_s;
          if (pick_d_s) begin
            mem_we_d    = port.d_we;
            mem_addr_d  = port.d_addr;
            mem_wdata_d = port.d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = port.if_addr;
            mem_wdata_d = '0;
          end
`ifdef ARB_RR_EN
          if (port.if_req && port.d_req) begin
            last_d = pick_d_s;
          end else begin
            last_d = last_q;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        // mem_ack takes precedence over the watchdog in the same cycle.
        if (port.mem_ack) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          if (gnt_sel_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = rsp_data_s;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = rsp_data_s;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          if (gnt_sel_q) begin
            d_ack_d = 1'b1;
          end else begin
            if_ack_d = 1'b1;
          end
        end else begin
          mem_req_d = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      gnt_sel_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_sel_q   <= gnt_sel_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign port.gnt_sel   = gnt_sel_q;
  assign port.mem_req   = mem_req_q;
  assign port.mem_we    = mem_we_q;
  assign port.mem_addr  = mem_addr_q;
  assign port.mem_wdata = mem_wdata_q;
  assign port.if_ack    = if_ack_q;
  assign port.d_ack     = d_ack_q;
  assign port.err       = err_q;
  assign port.if_rdata  = if_rdata_q;
  assign port.d_rdata   = d_rdata_q;

  // Stall follows the live request so the stage freezes in the request cycle.
  assign port.if_stall  = port.if_req & ~if_ack_q;
  assign port.d_stall   = port.d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: single fetch, data/fetch contention,
//   write, watchdog abort, ack on the last watchdog cycle, reset mid-transaction
//   and continuous contention (fixed priority or round-robin).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_seq;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0;
    bus.d_wdata   = 32'h0;
    bus.mem_rdata = 32'h0;
    bus.mem_ack   = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_mem_req",  64'(bus.mem_req),  64'h0);
    chk("rst_acks",     64'({bus.if_ack, bus.d_ack, bus.err}), 64'h0);
    chk("rst_gnt_sel",  64'(bus.gnt_sel),  64'h0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    chk("rst_wdata_we", 64'({bus.mem_wdata, bus.mem_we}), 64'h0);
    chk("rst_rdata",    64'({bus.if_rdata, bus.d_rdata}), 64'h0);
    rst = 1'b0;

    // ---- 1: single fetch, mem_ack in cycle 3 ----
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    #1;
    chk("t1_stall_c0", 64'(bus.if_stall), 64'h1);
    tick();  // cycle 1
    chk("t1_mem_req_c1", 64'(bus.mem_req),  64'h1);
    chk("t1_mem_addr",   64'(bus.mem_addr), 64'h100);
    chk("t1_gnt_sel",    64'(bus.gnt_sel),  64'h0);
    tick();  // cycle 2
    chk("t1_mem_req_c2", 64'(bus.mem_req),  64'h1);
    tick();  // cycle 3
    chk("t1_mem_req_c3", 64'(bus.mem_req),  64'h1);
    chk("t1_no_ack_c3",  64'(bus.if_ack),   64'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();  // cycle 4
    bus.mem_ack = 1'b0;
    chk("t1_if_ack",    64'(bus.if_ack),   64'h1);
    chk("t1_if_rdata",  64'(bus.if_rdata), 64'hDEAD_BEEF);
    chk("t1_err",       64'(bus.err),      64'h0);
    chk("t1_mem_req_c4", 64'(bus.mem_req), 64'h0);
    chk("t1_stall_c4",  64'(bus.if_stall), 64'h0);
    bus.if_req = 1'b0;
    tick();  // cycle 5
    chk("t1_ack_pulse", 64'(bus.if_ack),   64'h0);
    tick();
    chk("t1_no_regrant", 64'(bus.mem_req), 64'h0);

`ifdef ARB_RR_EN
    // One tie so the round-robin bit points back at data for the next tie.
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    tick();
    chk("rr_pre_gnt", 64'(bus.gnt_sel), 64'h0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    bus.d_req   = 1'b0;
    tick();
`endif

    // ---- 2: contention, data first then fetch ----
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0200;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_2000;
    #1;
    chk("t2_stalls_c0", 64'({bus.if_stall, bus.d_stall}), 64'h3);
    tick();  // cycle 1
    chk("t2_gnt_d",      64'(bus.gnt_sel),  64'h1);
    chk("t2_mem_addr_d", 64'(bus.mem_addr), 64'h2000);
    chk("t2_mem_we",     64'(bus.mem_we),   64'h0);
    tick();  // cycle 2
    chk("t2_gnt_hold",   64'(bus.gnt_sel),  64'h1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hA5A5_0001;
    tick();  // cycle 3
    bus.mem_ack = 1'b0;
    chk("t2_d_ack",      64'(bus.d_ack),    64'h1);
    chk("t2_d_rdata",    64'(bus.d_rdata),  64'hA5A5_0001);
    chk("t2_if_ack_c3",  64'(bus.if_ack),   64'h0);
    chk("t2_gnt_resp",   64'(bus.gnt_sel),  64'h1);
    chk("t2_if_stall_c3", 64'(bus.if_stall), 64'h1);
    bus.d_req = 1'b0;
    tick();  // cycle 4 (IDLE)
    chk("t2_idle_req",   64'(bus.mem_req),  64'h0);
    chk("t2_if_stall_c4", 64'(bus.if_stall), 64'h1);
    tick();  // cycle 5
    chk("t2_gnt_f",      64'(bus.gnt_sel),  64'h0);
    chk("t2_mem_addr_f", 64'(bus.mem_addr), 64'h200);
    chk("t2_if_stall_c5", 64'(bus.if_stall), 64'h1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    tick();  // cycle 6
    bus.mem_ack = 1'b0;
    chk("t2_if_ack",     64'(bus.if_ack),   64'h1);
    chk("t2_if_rdata",   64'(bus.if_rdata), 64'h0BAD_F00D);
    chk("t2_if_stall_c6", 64'(bus.if_stall), 64'h0);
    bus.if_req = 1'b0;
    tick();

    // ---- 3: write ----
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_2004;
    bus.d_wdata = 32'h1234_5678;
    tick();
    chk("t3_mem_we",    64'(bus.mem_we),    64'h1);
    chk("t3_mem_wdata", 64'(bus.mem_wdata), 64'h1234_5678);
    chk("t3_mem_addr",  64'(bus.mem_addr),  64'h2004);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.mem_ack = 1'b0;
    chk("t3_d_ack",     64'(bus.d_ack),     64'h1);
    chk("t3_d_rdata",   64'(bus.d_rdata),   64'h0);
    chk("t3_err",       64'(bus.err),       64'h0);
    chk("t3_we_stable", 64'({bus.mem_we, bus.mem_wdata}), 64'h1_1234_5678);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();

    // ---- 4: watchdog abort, then a stray mem_ack ----
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h0000_3000;
    bus.mem_rdata = 32'h5555_AAAA;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("t4_mem_req_c%0d", i), 64'(bus.mem_req), 64'h1);
    end
    tick();  // cycle 17
    chk("t4_d_ack",    64'(bus.d_ack),   64'h1);
    chk("t4_err",      64'(bus.err),     64'h1);
    chk("t4_d_rdata",  64'(bus.d_rdata), 64'h0);
    chk("t4_mem_req",  64'(bus.mem_req), 64'h0);
    bus.d_req = 1'b0;
    tick();  // cycle 18 (IDLE)
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("t4_stray_ack", 64'({bus.if_ack, bus.d_ack, bus.err, bus.mem_req}), 64'h0);
    tick();

    // ---- 4b: mem_ack on the last watchdog cycle wins ----
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_3100;
    for (int i = 1; i <= 16; i++) begin
      tick();
    end
    chk("t4b_mem_req_c16", 64'(bus.mem_req), 64'h1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h7777_0016;
    tick();
    bus.mem_ack = 1'b0;
    chk("t4b_d_ack",   64'(bus.d_ack),   64'h1);
    chk("t4b_err",     64'(bus.err),     64'h0);
    chk("t4b_d_rdata", 64'(bus.d_rdata), 64'h7777_0016);
    bus.d_req = 1'b0;
    tick();

    // ---- 5: reset in the 2nd BUSY cycle of a fetch ----
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0400;
    tick();  // BUSY 1
    tick();  // BUSY 2
    chk("t5_busy2", 64'(bus.mem_req), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_mem_req", 64'(bus.mem_req),  64'h0);
    chk("t5_rst_no_ack",  64'(bus.if_ack),   64'h0);
    chk("t5_rst_addr",    64'(bus.mem_addr), 64'h0);
    tick();
    chk("t5_regrant",      64'(bus.mem_req),  64'h1);
    chk("t5_regrant_addr", 64'(bus.mem_addr), 64'h400);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hC0DE_0005;
    tick();
    bus.mem_ack = 1'b0;
    chk("t5_if_ack",   64'(bus.if_ack),   64'h1);
    chk("t5_if_rdata", 64'(bus.if_rdata), 64'hC0DE_0005);
    bus.if_req = 1'b0;
    tick();

    // ---- 6: both requests held continuously ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b1111;
`endif
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0500;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h0000_0600;
    for (int k = 0; k < 4; k++) begin
      tick();  // BUSY
      chk($sformatf("t6_gnt_%0d", k), 64'(bus.gnt_sel), 64'(exp_seq[k]));
      chk($sformatf("t6_addr_%0d", k), 64'(bus.mem_addr),
          exp_seq[k] ? 64'h600 : 64'h500);
      bus.mem_ack = 1'b1;
      tick();  // RESP
      bus.mem_ack = 1'b0;
      chk($sformatf("t6_ack_%0d", k), 64'({bus.d_ack, bus.if_ack}),
          exp_seq[k] ? 64'h2 : 64'h1);
      tick();  // IDLE, requests renewed
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
